// File: rtl/draw_text_line.sv
// Text-overlay stage for the VGA chain: looks up characters and font lines from external
// ROMs and paints TEXT_COLOR over the incoming pixel wherever a font bit is set in the box.
module draw_text_line #(
    parameter logic [10:0] X_POS      = 11'd0,
    parameter logic [10:0] Y_POS      = 11'd0,
    parameter int          COLS       = 32,
    parameter int          ROWS       = 1,
    parameter logic [11:0] TEXT_COLOR = 12'hfff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [6:0]  char_code,
    input  logic [7:0]  char_pixels,
    output logic [11:0] char_xy,
    output logic [10:0] font_addr,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Box limits are one bit wider so a box reaching the screen edge cannot wrap.
    localparam logic [11:0] X_END = {1'b0, X_POS} + 12'(8 * COLS);
    localparam logic [11:0] Y_END = {1'b0, Y_POS} + 12'(16 * ROWS);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    timing_t     tim_in;
    timing_t     tim_s1;
    timing_t     tim_s2;
    timing_t     tim_s3;
    logic [11:0] rgb_s1;
    logic [11:0] rgb_s2;
    logic [11:0] rgb_s3;
    logic [3:0]  line_s1;
    logic [2:0]  bit_s1;
    logic [2:0]  bit_s2;
    logic        in_box_s1;
    logic        in_box_s2;
    logic        pix_s3;

    logic [9:0]  rel_x;
    logic [8:0]  rel_y;
    logic        in_box;
    logic [6:0]  col;
    logic [4:0]  row;

    assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                      vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

    always_comb begin
        rel_x  = 10'(hcount_in - X_POS);
        rel_y  = 9'(vcount_in - Y_POS);
        col    = rel_x[9:3];
        row    = rel_y[8:4];
        in_box = ({1'b0, hcount_in} >= {1'b0, X_POS}) && ({1'b0, hcount_in} < X_END) &&
                 ({1'b0, vcount_in} >= {1'b0, Y_POS}) && ({1'b0, vcount_in} < Y_END) &&
                 !hblnk_in && !vblnk_in;
    end

    // Stage 1: character ROM address plus everything the later stages need.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_xy   <= '0;
            line_s1   <= '0;
            bit_s1    <= '0;
            in_box_s1 <= 1'b0;
            tim_s1    <= '0;
            rgb_s1    <= '0;
        end else begin
            char_xy   <= in_box ? {row, col} : 12'h000;
            line_s1   <= rel_y[3:0];
            bit_s1    <= rel_x[2:0];
            in_box_s1 <= in_box;
            tim_s1    <= tim_in;
            rgb_s1    <= rgb_in;
        end
    end

    // Stage 2: char_code for this pixel arrives now; form the font line address.
    always_ff @(posedge clk) begin
        if (rst) begin
            font_addr <= '0;
            bit_s2    <= '0;
            in_box_s2 <= 1'b0;
            tim_s2    <= '0;
            rgb_s2    <= '0;
        end else begin
            font_addr <= {char_code, line_s1};
            bit_s2    <= bit_s1;
            in_box_s2 <= in_box_s1;
            tim_s2    <= tim_s1;
            rgb_s2    <= rgb_s1;
        end
    end

    // Stage 3: font line arrives; pick out this pixel's bit (MSB is leftmost).
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_s3 <= 1'b0;
            tim_s3 <= '0;
            rgb_s3 <= '0;
        end else begin
            pix_s3 <= in_box_s2 && char_pixels[3'd7 - bit_s2];
            tim_s3 <= tim_s2;
            rgb_s3 <= rgb_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out    <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
        end else begin
            rgb_out    <= pix_s3 ? TEXT_COLOR : rgb_s3;
            hcount_out <= tim_s3.hcount;
            vcount_out <= tim_s3.vcount;
            hsync_out  <= tim_s3.hsync;
            vsync_out  <= tim_s3.vsync;
            hblnk_out  <= tim_s3.hblnk;
            vblnk_out  <= tim_s3.vblnk;
        end
    end

endmodule

// File: tb/tb_draw_text_line.sv
// Bench for draw_text_line: ROM models, a hand-derived vector table, and a scoreboard
// that expects each pixel 4 clocks after it is driven.
module tb_draw_text_line;

    localparam logic [10:0] X_POS      = 11'd100;
    localparam logic [10:0] Y_POS      = 11'd50;
    localparam int          COLS       = 27;
    localparam int          ROWS       = 2;
    localparam logic [11:0] TEXT_COLOR = 12'hfff;
    localparam int          X_END      = 100 + 8 * COLS;
    localparam int          Y_END      = 50 + 16 * ROWS;

    logic        clk;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [6:0]  char_code;
    logic [7:0]  char_pixels;
    logic [11:0] char_xy;
    logic [10:0] font_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int vectors;
    int miscompares;

    draw_text_line #(
        .X_POS(X_POS), .Y_POS(Y_POS), .COLS(COLS), .ROWS(ROWS), .TEXT_COLOR(TEXT_COLOR)
    ) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .char_code(char_code), .char_pixels(char_pixels),
        .char_xy(char_xy), .font_addr(font_addr),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Text ROM: code 0x31 at col 26 row 0, a space at col 9 row 0.
    function automatic logic [6:0] charRom(input logic [11:0] xy);
        return 7'(xy[6:0] + 7'(xy[11:7] * 3) + 7'h17);
    endfunction

    function automatic logic [7:0] fontRom(input logic [10:0] a);
        if (a[10:4] == 7'h20) return 8'h00;
        if (a[10:4] == 7'h31) return 8'h81;
        return {1'b0, a[10:4]} ^ {a[3:0], a[3:0]};
    endfunction

    assign char_code   = charRom(char_xy);
    assign char_pixels = fontRom(font_addr);

    function automatic logic modelInBox(input logic [10:0] h, v, input logic hb, vb);
        return (int'(h) >= int'(X_POS)) && (int'(h) < X_END) &&
               (int'(v) >= int'(Y_POS)) && (int'(v) < Y_END) && !hb && !vb;
    endfunction

    function automatic logic [11:0] modelXy(input logic [10:0] h, v, input logic hb, vb);
        logic [9:0] rx;
        logic [8:0] ry;
        rx = 10'(h - X_POS);
        ry = 9'(v - Y_POS);
        return modelInBox(h, v, hb, vb) ? {ry[8:4], rx[9:3]} : 12'h000;
    endfunction

    function automatic logic [11:0] modelRgb(input logic [10:0] h, v, input logic hb, vb,
                                             input logic [11:0] rgb);
        logic [2:0] bx;
        logic [3:0] ln;
        logic [7:0] px;
        bx = 3'(h - X_POS);
        ln = 4'(v - Y_POS);
        px = fontRom({charRom(modelXy(h, v, hb, vb)), ln});
        return (modelInBox(h, v, hb, vb) && px[3'd7 - bx]) ? TEXT_COLOR : rgb;
    endfunction

    typedef struct {
        logic        r;
        logic [10:0] h, v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
        logic [11:0] xy;
        logic [10:0] font;
    } exp_t;

    typedef struct {
        logic [10:0] h, v;
        logic        hs, hb;
        logic [11:0] rgb;
        logic [11:0] exp_rgb;
        logic [11:0] exp_xy;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];

    task automatic reportFail(input string name, input logic [31:0] got, input logic [31:0] want);
        miscompares++;
        $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    endtask

    task automatic checkOutput();
        exp_t last;
        exp_t e;
        logic [10:0] want_font;
        last = sb[sb.size() - 1];
        vectors++;
        if (char_xy !== last.xy) reportFail("char_xy", 32'(char_xy), 32'(last.xy));
        if (last.r || sb.size() >= 2) begin
            want_font = last.r ? 11'h000 : sb[sb.size() - 2].font;
            vectors++;
            if (font_addr !== want_font) reportFail("font_addr", 32'(font_addr), 32'(want_font));
        end
        if (sb.size() == 4) begin
            e = sb.pop_front();
            vectors++;
            if (rgb_out !== e.rgb) reportFail("rgb_out", 32'(rgb_out), 32'(e.rgb));
            vectors++;
            if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
                {e.h, e.v, e.hs, e.vs, e.hb, e.vb})
                reportFail("timing_out",
                           32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                           32'({e.h, e.v, e.hs, e.vs, e.hb, e.vb}));
        end
    endtask

    // Drives one pixel, records what must come out of it, then advances one clock.
    task automatic applyStimulus(input logic r, input logic [10:0] h, v,
                                 input logic hs, vs, hb, vb, input logic [11:0] rgb,
                                 input logic use_tab, input logic [11:0] t_rgb, t_xy);
        exp_t e;
        rst = r; hcount_in = h; vcount_in = v;
        hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
        if (r) begin
            e = '{r: 1'b1, h: '0, v: '0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0,
                  rgb: '0, xy: '0, font: {charRom(12'h000), 4'h0}};
            foreach (sb[i]) sb[i] = e;
        end else begin
            e.r = 1'b0; e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
            e.rgb  = use_tab ? t_rgb : modelRgb(h, v, hb, vb, rgb);
            e.xy   = use_tab ? t_xy : modelXy(h, v, hb, vb);
            e.font = {charRom(e.xy), 4'(v - Y_POS)};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        vecs[0]  = '{11'd5,   11'd0,  1'b0, 1'b0, 12'h123, 12'h123, 12'h000};
        vecs[1]  = '{11'd311, 11'd57, 1'b0, 1'b0, 12'h00f, 12'h00f, 12'h01a};
        vecs[2]  = '{11'd308, 11'd57, 1'b0, 1'b0, 12'h00f, 12'hfff, 12'h01a};
        vecs[3]  = '{11'd309, 11'd57, 1'b0, 1'b0, 12'h00f, 12'h00f, 12'h01a};
        vecs[4]  = '{11'd312, 11'd57, 1'b0, 1'b0, 12'h00f, 12'h00f, 12'h01a};
        vecs[5]  = '{11'd315, 11'd57, 1'b0, 1'b0, 12'h00f, 12'hfff, 12'h01a};
        vecs[6]  = '{11'd316, 11'd57, 1'b0, 1'b0, 12'h00f, 12'h00f, 12'h000};
        vecs[7]  = '{11'd99,  11'd57, 1'b0, 1'b0, 12'h00f, 12'h00f, 12'h000};
        vecs[8]  = '{11'd308, 11'd57, 1'b1, 1'b1, 12'h00f, 12'h00f, 12'h000};
        vecs[9]  = '{11'd172, 11'd50, 1'b0, 1'b0, 12'h0a5, 12'h0a5, 12'h009};
        vecs[10] = '{11'd103, 11'd66, 1'b0, 1'b0, 12'h321, 12'hfff, 12'h080};
        vecs[11] = '{11'd100, 11'd66, 1'b0, 1'b0, 12'h321, 12'h321, 12'h080};
        vecs[12] = '{11'd103, 11'd82, 1'b0, 1'b0, 12'h321, 12'h321, 12'h000};
        vecs[13] = '{11'd103, 11'd49, 1'b0, 1'b0, 12'h456, 12'h456, 12'h000};

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 12'($urandom), 1'b0, 12'h0, 12'h0);
        vectors++;
        if ({rgb_out, char_xy, font_addr, hcount_out, vcount_out,
             hsync_out, vsync_out, hblnk_out, vblnk_out} !== '0)
            reportFail("reset_outputs", 32'({rgb_out, char_xy, font_addr}), 32'h0);

        for (int i = 0; i < 14; i++)
            applyStimulus(1'b0, vecs[i].h, vecs[i].v, vecs[i].hs, 1'b0, vecs[i].hb, 1'b0,
                          vecs[i].rgb, 1'b1, vecs[i].exp_rgb, vecs[i].exp_xy);

        applyStimulus(1'b0, 11'd311, 11'd57, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00f, 1'b0, 12'h0, 12'h0);
        vectors++;
        if (char_xy !== 12'h01a) reportFail("addr_char_xy", 32'(char_xy), 32'h01a);
        applyStimulus(1'b0, 11'd312, 11'd57, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00f, 1'b0, 12'h0, 12'h0);
        vectors++;
        if (font_addr !== 11'h317) reportFail("addr_font", 32'(font_addr), 32'h317);

        // A slice of 640x480 frames around the text box, with a one-cycle reset mid-line.
        for (int v = 44; v < 90; v++) begin
            for (int h = 0; h < 800; h++) begin
                logic [10:0] hh, vv;
                logic hb, vb;
                hh = 11'(h);
                vv = 11'(v);
                hb = (h >= 640);
                vb = (v >= 480);
                applyStimulus((v == 60 && h == 200), hh, vv,
                              (h >= 656 && h < 752), (v >= 490 && v < 492), hb, vb,
                              (hb || vb) ? 12'h000 : {hh[3:0], vv[3:0], hh[7:4]},
                              1'b0, 12'h0, 12'h0);
            end
        end

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 11'd5, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0f0, 1'b0, 12'h0, 12'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
